// File: rtl/btn_trig_conditioner.sv
// Raw push-button to single-cycle trig: 2-FF synchronizer, debounce counter, press/release FSM.
// Define BTN_REPEAT_EN to add auto-repeat trig pulses while the button stays held.
module btn_trig_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic trig,
  output logic btn_level,
  output logic busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((DEBOUNCE_CYCLES < 2) || (REPEAT_PERIOD < 2) ||
      ((2 ** CNT_W) <= DEBOUNCE_CYCLES) || ((2 ** CNT_W) <= REPEAT_DELAY) ||
      ((2 ** CNT_W) <= REPEAT_PERIOD)) begin : g_param_err
    $error("btn_trig_conditioner: illegal parameter combination");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_trig_nxt;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // r_rep_first selects the initial delay versus the steady repeat period
  logic             r_rep_first;
  logic             w_rep_first_nxt;
  logic [CNT_W-1:0] w_rep_last;

  assign w_rep_last = r_rep_first ? RD_LAST : RP_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_first <= 1'b1;
    end else begin
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      trig      <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_sync0   <= btn_in;
      r_sync1   <= r_sync0;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      trig      <= w_trig_nxt;
      btn_level <= (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_WAIT);
      busy      <= (w_state_nxt == S_PRESS_WAIT) || (w_state_nxt == S_RELEASE_WAIT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = 1'b0;
`ifdef BTN_REPEAT_EN
    w_rep_first_nxt = r_rep_first;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_sync1) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      S_PRESS_WAIT: begin
        if (!r_sync1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = CNT_ZERO;
          w_trig_nxt  = 1'b1;
`ifdef BTN_REPEAT_EN
          w_rep_first_nxt = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!r_sync1) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
`ifdef BTN_REPEAT_EN
          // while held the debounce counter is free, so it times the repeats
          if (r_cnt == w_rep_last) begin
            w_trig_nxt      = 1'b1;
            w_cnt_nxt       = CNT_ZERO;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
`endif
        end
      end
      S_RELEASE_WAIT: begin
        if (r_sync1) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = CNT_ZERO;
`ifdef BTN_REPEAT_EN
          w_rep_first_nxt = 1'b1;
`endif
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_trig_conditioner.sv
// Bench for btn_trig_conditioner: directed scenarios plus random bouncing input,
// all compared every cycle against a streak-based behavioural model.
module tb_btn_trig_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic trig;
  logic btn_level;
  logic busy;

  always #5 clk = ~clk;

  btn_trig_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .trig(trig),
    .btn_level(btn_level),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  // Model: the debounced level flips once D+1 consecutive synchronized samples
  // disagree with it; busy means a disagreeing streak is in progress.
  logic m_s0 = 1'b0, m_s1 = 1'b0, m_lvl = 1'b0, m_trig = 1'b0, m_samp;
  int   m_streak = 0, m_start = 0, m_d;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    ecnt++;
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_lvl = 0; m_trig = 0; m_streak = 0; m_start = 0;
      m_valid = 1'b1;
    end else begin
      m_samp = m_s1; m_s1 = m_s0; m_s0 = btn_in;
      m_trig = 0;
      if (m_samp != m_lvl) begin
        if (m_streak == D) begin
          m_lvl = m_samp; m_streak = 0; m_trig = m_samp; m_start = ecnt;
        end else begin
          m_streak++;
        end
      end else begin
        if (m_streak > 0 && m_lvl) m_start = ecnt;
`ifdef BTN_REPEAT_EN
        else if (m_lvl) begin
          m_d = ecnt - m_start;
          if (m_d >= RD && (m_d - RD) % RP == 0) m_trig = 1;
        end
`endif
        m_streak = 0;
      end
    end
  end

  int trig_cnt = 0, fall_cnt = 0;
  int first_trig_edge = -1, last_trig_edge = -1, last_fall_edge = -1;
  logic prev_lvl = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (trig !== m_trig || btn_level !== m_lvl || busy !== (m_streak > 0)) begin
        failures++;
        $display("FAIL cycle_cmp edge=%0d trig=%b want=%b btn_level=%b want=%b busy=%b want=%b",
                 ecnt, trig, m_trig, btn_level, m_lvl, busy, (m_streak > 0));
      end
      if (trig === 1'b1) begin
        trig_cnt++;
        last_trig_edge = ecnt;
        if (first_trig_edge < 0) first_trig_edge = ecnt;
      end
      if (prev_lvl === 1'b1 && btn_level === 1'b0) begin
        fall_cnt++;
        last_fall_edge = ecnt;
      end
      prev_lvl = btn_level;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  int n0, m0, t0, f0, dig, seglen;
  logic val;

  initial begin
    #1;
    rst = 1'b1;
    btn_in = 1'b0;
    step(3);
    check("reset_trig", int'(trig), 0);
    check("reset_level", int'(btn_level), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    step(5);

    // clean press
    t0 = trig_cnt; first_trig_edge = -1;
    btn_in = 1'b1; n0 = ecnt + 1;
    step(3);
    check("press_wait_busy", int'(busy), 1);
    step(27);
    btn_in = 1'b0; m0 = ecnt + 1;
    step(15);
    check("clean_trig_edge", first_trig_edge, n0 + D + 2);
`ifndef BTN_REPEAT_EN
    check("clean_trig_count", trig_cnt - t0, 1);
`endif
    check("clean_fall_edge", last_fall_edge, m0 + D + 2);

    // press bounce
    t0 = trig_cnt;
    btn_in = 1'b1; step(2);
    btn_in = 1'b0; step(1);
    btn_in = 1'b1; step(2);
    btn_in = 1'b0; step(12);
    check("bounce_no_trig", trig_cnt - t0, 0);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_idle", int'(busy), 0);

    // release bounce
    btn_in = 1'b1; step(12);
    t0 = trig_cnt; f0 = fall_cnt;
    btn_in = 1'b0; step(2);
    btn_in = 1'b1; step(10);
    check("rel_bounce_level", int'(btn_level), 1);
    check("rel_bounce_no_fall", fall_cnt - f0, 0);
`ifndef BTN_REPEAT_EN
    check("rel_bounce_no_trig", trig_cnt - t0, 0);
`endif
    btn_in = 1'b0; m0 = ecnt + 1;
    step(12);
    check("rel_bounce_fall_edge", last_fall_edge, m0 + D + 2);
    check("rel_bounce_one_fall", fall_cnt - f0, 1);

    // reset while in PRESS_WAIT with cnt=2
    btn_in = 1'b1; n0 = ecnt + 1;
    step(5);
    rst = 1'b1;
    step(1);
    check("midrst_trig", int'(trig), 0);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0; first_trig_edge = -1;
    step(10);
    check("midrst_trig_edge", first_trig_edge, n0 + 12);
    btn_in = 1'b0; step(12);

    // chain of 5 presses into a mod-5 digit counter
    t0 = trig_cnt; dig = 0;
    for (int i = 0; i < 5; i++) begin
      f0 = trig_cnt;
      btn_in = 1'b1; step(10);
      btn_in = 1'b0; step(10);
      dig = (dig + (trig_cnt - f0)) % 5;
      check("chain_digit", dig, (i + 1) % 5);
    end
    check("chain_trig_count", trig_cnt - t0, 5);

`ifdef BTN_REPEAT_EN
    // auto-repeat: hold until edge T+30 still sees HELD
    t0 = trig_cnt; first_trig_edge = -1;
    btn_in = 1'b1; n0 = ecnt + 1;
    step(35);
    btn_in = 1'b0;
    step(15);
    check("rep_first_edge", first_trig_edge, n0 + D + 2);
    check("rep_trig_count", trig_cnt - t0, 7);
    check("rep_last_offset", last_trig_edge - first_trig_edge, 30);
`endif

    // random bouncing input with occasional resets
    val = 1'b0;
    for (int s = 0; s < 400; s++) begin
      val = ~val;
      btn_in = val;
      if ($urandom_range(0, 2) == 0) seglen = $urandom_range(1, 4);
      else seglen = $urandom_range(1, 20);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; step(1); rst = 1'b0;
      end
      step(seglen);
    end
    btn_in = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
